multicycle_alu: RTL and testbench

- Parametrised, clocked successor of the datapath combinational ALU.
- Keeps the single-cycle AND/OR/ADD/SUB/SLT operations, now with a registered result.
- Adds a shift-add unsigned multiplier (MULTU) and a restoring unsigned divider (DIVU), both multi-cycle, writing HI/LO registers.
- Sits in the EX stage; the controller issues via start and stalls on busy until done.

---
 rtl/multicycle_alu.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_alu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Brief    : Clocked ALU with single-cycle logic/arith ops plus multi-cycle
//            shift-add MULTU and restoring DIVU writing HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_SLT   = 3'd4;
  localparam logic [2:0] OP_MULTU = 3'd5;
  localparam logic [2:0] OP_DIVU  = 3'd6;
  localparam logic [2:0] OP_OFF   = 3'd7;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;    // MUL: product accumulator; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   opb_q;    // multiplier (shifted right) or divisor
  logic [WIDTH-1:0]   y_q;
  logic               zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;

  logic [WIDTH-1:0]   alu_res_d;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     div_sh_d;
  logic [WIDTH:0]     div_diff_d;
  logic [2*WIDTH-1:0] div_next_d;

  always_comb begin
    alu_res_d = '0;
    case (alu_op)
      OP_AND:  alu_res_d = a & b;
      OP_OR:   alu_res_d = a | b;
      OP_ADD:  alu_res_d = a + b;
      OP_SUB:  alu_res_d = a - b;
      OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res_d = '0;
    endcase
  end

  assign mul_acc_d = opb_q[0] ? (acc_q + mcand_q) : acc_q;

  // Partial remainder is always below the divisor, so the shifted value fits in
  // WIDTH+1 bits and a clear MSB of the difference means "subtract succeeded".
  assign div_sh_d   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff_d = div_sh_d - {1'b0, opb_q};
  assign div_next_d = div_diff_d[WIDTH]
                    ? {div_sh_d[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                    : {div_diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      opb_q      <= '0;
      y_q        <= '0;
      zero_q     <= 1'b1;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            div_zero_q <= 1'b0;
            case (alu_op)
              OP_MULTU: begin
                state_q <= S_MUL;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                acc_q   <= '0;
                mcand_q <= {{WIDTH{1'b0}}, a};
                opb_q   <= b;
              end
              OP_DIVU: begin
                if (b == '0) begin
                  hi_q       <= a;
                  lo_q       <= '1;
                  y_q        <= '1;
                  zero_q     <= 1'b0;
                  div_zero_q <= 1'b1;
                  done_q     <= 1'b1;
                end else begin
                  state_q <= S_DIV;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  acc_q   <= {{WIDTH{1'b0}}, a};
                  opb_q   <= b;
                end
              end
              OP_OFF: done_q <= 1'b1;
              default: begin
                y_q    <= alu_res_d;
                zero_q <= (alu_res_d == '0);
                done_q <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          acc_q   <= mul_acc_d;
          mcand_q <= mcand_q << 1;
          opb_q   <= opb_q >> 1;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            hi_q    <= mul_acc_d[2*WIDTH-1:WIDTH];
            lo_q    <= mul_acc_d[WIDTH-1:0];
            y_q     <= mul_acc_d[WIDTH-1:0];
            zero_q  <= (mul_acc_d[WIDTH-1:0] == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DIV: begin
          acc_q <= div_next_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            hi_q    <= div_next_d[2*WIDTH-1:WIDTH];
            lo_q    <= div_next_d[WIDTH-1:0];
            y_q     <= div_next_d[WIDTH-1:0];
            zero_q  <= (div_next_d[WIDTH-1:0] == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign y        = y_q;
  assign zero     = zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_alu
// Brief    : Directed self-checking bench for multicycle_alu (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  int checks;
  int failures;

  multicycle_alu #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .y(y), .zero(zero), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start for a single edge; returns 1ns after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    start = 1'b1; alu_op = op; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycles until done rises (0 on timeout); busy_ok drops if busy fell early.
  task automatic wait_done(output int n, output bit busy_ok);
    n = 0; busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; alu_op = 3'd2; a = 32'd1; b = 32'd1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    checks++;
    if (y !== 32'd0 || zero !== 1'b1 || hi !== 32'd0 || lo !== 32'd0 ||
        busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset: y=%h zero=%b hi=%h lo=%h busy=%b done=%b dz=%b, required 0 1 0 0 0 0 0",
               y, zero, hi, lo, busy, done, div_zero);
    end
  endtask

  task automatic test_add_sub;
    issue(3'd2, 32'd8, 32'd41);
    checks++;
    if (y !== 32'd49 || zero !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL add: y=%0d zero=%b done=%b busy=%b, required 49 0 1 0", y, zero, done, busy);
    end
    issue(3'd7, 32'd1, 32'd1);
    checks++;
    if (y !== 32'd49 || done !== 1'b1) begin
      failures++;
      $display("FAIL off: y=%0d done=%b, required 49 1", y, done);
    end
    issue(3'd3, 32'd8, 32'd8);
    checks++;
    if (y !== 32'd0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL sub: y=%0d zero=%b, required 0 1", y, zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_single_pulse: done=%b, required 0", done);
    end
  endtask

  // Start held high across four SLTs: also exercises back-to-back single-cycle issue.
  task automatic test_slt;
    logic [WIDTH-1:0] va [4] = '{32'd41, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd8};
    logic [WIDTH-1:0] vb [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'd41};
    logic [WIDTH-1:0] ex [4] = '{32'd0, 32'd0, 32'd1, 32'd1};
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; alu_op = 3'd4; a = va[i]; b = vb[i];
      @(posedge clk); #1;
      checks++;
      if (y !== ex[i] || done !== 1'b1) begin
        failures++;
        $display("FAIL slt[%0d]: y=%0d done=%b, required %0d 1", i, y, done, ex[i]);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_multu;
    int n; bit bok;
    issue(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL multu_busy: busy=%b done=%b, required 1 0", busy, done);
    end
    wait_done(n, bok);
    checks++;
    if (n != 32 || !bok || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || y !== 32'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL multu: cycles=%0d busy_ok=%b hi=%h lo=%h y=%h busy=%b, required 32 1 fffffffe 00000001 00000001 0",
               n, bok, hi, lo, y, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL multu_done_once: done=%b, required 0", done);
    end
  endtask

  task automatic test_divu;
    int n; bit bok;
    issue(3'd6, 32'd100, 32'd7);
    wait_done(n, bok);
    checks++;
    if (n != 32 || !bok || lo !== 32'd14 || hi !== 32'd2 || y !== 32'd14 || zero !== 1'b0) begin
      failures++;
      $display("FAIL divu: cycles=%0d busy_ok=%b lo=%0d hi=%0d y=%0d zero=%b, required 32 1 14 2 14 0",
               n, bok, lo, hi, y, zero);
    end
    issue(3'd6, 32'd5, 32'd0);
    checks++;
    if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF || y !== 32'hFFFF_FFFF || zero !== 1'b0 ||
        div_zero !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL divu_zero: hi=%h lo=%h y=%h zero=%b dz=%b done=%b busy=%b, required 5 ffffffff ffffffff 0 1 1 0",
               hi, lo, y, zero, div_zero, done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (div_zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL divu_zero_sticky: dz=%b busy=%b done=%b, required 1 0 0", div_zero, busy, done);
    end
    issue(3'd2, 32'd1, 32'd2);
    checks++;
    if (div_zero !== 1'b0 || y !== 32'd3) begin
      failures++;
      $display("FAIL div_zero_clear: dz=%b y=%0d, required 0 3", div_zero, y);
    end
  endtask

  task automatic test_back_to_back;
    int n; bit bok;
    issue(3'd5, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; alu_op = 3'd2; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, bok);
    // Issued edge was the 10th; 22 more edges remain to done.
    checks++;
    if (n != 22 || !bok || hi !== 32'd0 || lo !== 32'd7006652 || y !== 32'd7006652) begin
      failures++;
      $display("FAIL multu_ignore_start: cycles=%0d busy_ok=%b hi=%0d lo=%0d y=%0d, required 22 1 0 7006652 7006652",
               n, bok, hi, lo, y);
    end
    issue(3'd2, 32'd20, 32'd22);
    checks++;
    if (y !== 32'd42 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_in_done_cycle: y=%0d done=%b busy=%b, required 42 1 0", y, done, busy);
    end
  endtask

  task automatic test_reset_abort;
    bit saw_done;
    issue(3'd6, 32'd1000, 32'd3);
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL divu_inflight: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (y !== 32'd0 || zero !== 1'b1 || hi !== 32'd0 || lo !== 32'd0 ||
        busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort: y=%h zero=%b hi=%h lo=%h busy=%b done=%b dz=%b, required 0 1 0 0 0 0 0",
               y, zero, hi, lo, busy, done, div_zero);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL reset_abort_quiet: activity=%b, required 0", saw_done);
    end
    issue(3'd2, 32'd2, 32'd3);
    checks++;
    if (y !== 32'd5 || zero !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL add_after_reset: y=%0d zero=%b done=%b, required 5 0 1", y, zero, done);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; alu_op = 3'd0; a = '0; b = '0;
    @(posedge clk); #1;
    test_reset;
    test_add_sub;
    test_slt;
    test_multu;
    test_divu;
    test_back_to_back;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
